// File: rtl/alu_mul_seq.sv
// Iterative 32x32 shift-add multiplier that borrows the shared CPU ALU for its adds.
// Optional two's-complement mode is compiled in with `define ALU_MUL_SIGNED_EN.
module alu_mul_seq #(
  parameter int ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] mcand_i,
  input  logic [31:0] mplier_i,
`ifdef ALU_MUL_SIGNED_EN
  input  logic        mul_signed_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o,
  output logic        alu_own_o,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_op_o,
  input  logic [31:0] alu_result_i
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [4:0] LAST    = 5'(ITER - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] hi, lo, mc;
  logic [4:0]  cnt;
  logic        start_ok, carry;
  logic [31:0] hi_step, lo_step, mc_cap, lo_cap;
  logic [63:0] prod_step;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    alu_own_o  = 1'b0;
    alu_src1_o = '0;
    alu_src2_o = '0;
    alu_op_o   = '0;
    case (state)
      IDLE: begin
        if (start_i) begin
          start_ok  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        alu_own_o  = 1'b1;
        alu_src1_o = hi;
        alu_src2_o = lo[0] ? mc : '0;
        alu_op_o   = ALU_ADD;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (start_i) begin
          start_ok  = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The ALU is only 32 bits wide, so the carry-out is rebuilt from the operand and result MSBs.
  always_comb begin
    carry   = (alu_src1_o[31] & alu_src2_o[31]) |
              ((alu_src1_o[31] | alu_src2_o[31]) & ~alu_result_i[31]);
    hi_step = {carry, alu_result_i[31:1]};
    lo_step = {alu_result_i[0], lo[31:1]};
  end

`ifdef ALU_MUL_SIGNED_EN
  logic sign;

  // Signed operands are reduced to magnitudes; the sign is reapplied to the final product.
  always_comb begin
    mc_cap    = (mul_signed_i && mcand_i[31])  ? -mcand_i  : mcand_i;
    lo_cap    = (mul_signed_i && mplier_i[31]) ? -mplier_i : mplier_i;
    prod_step = sign ? -{hi_step, lo_step} : {hi_step, lo_step};
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)        sign <= 1'b0;
    else if (start_ok) sign <= mul_signed_i & (mcand_i[31] ^ mplier_i[31]);
  end
`else
  always_comb begin
    mc_cap    = mcand_i;
    lo_cap    = mplier_i;
    prod_step = {hi_step, lo_step};
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      mc        <= '0;
      cnt       <= '0;
      product_o <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        hi  <= '0;
        lo  <= lo_cap;
        mc  <= mc_cap;
        cnt <= '0;
      end else if (state == BUSY) begin
        hi  <= hi_step;
        lo  <= lo_step;
        cnt <= cnt + 5'd1;
        if (cnt == LAST) product_o <= prod_step;
      end
    end
  end

  assign busy_o = (state == BUSY);
  assign done_o = (state == DONE);

endmodule
